regfile_mp: RTL

//  Parametrised multi-read-port integer register file for the pipelined RISC-V core.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_scoreboard.sv | 45 ++++
 rtl/regfile_mp.sv | 77 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding, default sizes and the x0 address for regfile_mp
package regfile_pkg;
   typedef enum logic {RF_INIT, RF_READY} rf_state_t;
   localparam int DEF_WIDTH      = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_NUM_READ   = 2;
   localparam int ZERO_REG       = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with reserve/retire and per-port busy query (bypass via REGFILE_BYPASS_EN)
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_READ   = DEF_NUM_READ
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           ready,
   input  logic                           wr_fire,
   input  logic [ADDR_WIDTH-1:0]          wr_addr,
   input  logic                           rsv_en,
   input  logic [ADDR_WIDTH-1:0]          rsv_addr,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_READ-1:0]            rd_busy,
   output logic                           rsv_ok
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_REG);

   logic [DEPTH-1:0] busy, busy_eff, wr_clr;

   // retiring write hides its busy bit in the same cycle only when forwarding is built in
   always_comb begin
      wr_clr = '0;
`ifdef REGFILE_BYPASS_EN
      wr_clr[wr_addr] = wr_fire;
`endif
      busy_eff = busy & ~wr_clr;
      rsv_ok = ready && rsv_en && (rsv_addr == ZERO || !busy_eff[rsv_addr]);
      for (int i = 0; i < NUM_READ; i++)
         rd_busy[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != ZERO && busy_eff[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
   end

   // reservation is applied after the retire so a same-address pair leaves the bit set
   always_ff @(posedge clock) begin
      if (reset) begin
         busy <= '0;
      end else begin
         if (wr_fire) busy[wr_addr] <= 1'b0;
         if (rsv_ok && rsv_addr != ZERO) busy[rsv_addr] <= 1'b1;
      end
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with x0 zero, post-reset clear and busy scoreboard; REGFILE_BYPASS_EN enables write->read forwarding
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_READ   = DEF_NUM_READ
) (
   input  logic                           clock,
   input  logic                           reset,
   output logic                           init_done,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_READ*WIDTH-1:0]      rd_data,
   output logic [NUM_READ-1:0]            rd_busy,
   input  logic                           wr_en,
   input  logic [ADDR_WIDTH-1:0]          wr_addr,
   input  logic [WIDTH-1:0]               wr_data,
   input  logic                           rsv_en,
   input  logic [ADDR_WIDTH-1:0]          rsv_addr,
   output logic                           rsv_ok
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_REG);

   rf_state_t             state, state_next;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic [WIDTH-1:0]      regs [DEPTH];
   logic                  ready, wr_fire;

   assign ready     = state == RF_READY;
   assign init_done = ready;
   assign wr_fire   = ready && wr_en && wr_addr != ZERO;

   // clear sequence ends once the last register has been zeroed
   always_comb state_next = (state == RF_INIT && clr_cnt == '1) ? RF_READY : state;

   // state register and clear counter, restarted by any reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= RF_INIT;
         clr_cnt <= '0;
      end else begin
         state   <= state_next;
         clr_cnt <= ready ? clr_cnt : clr_cnt + ADDR_WIDTH'(1);
      end
   end

   // data array: zeroed one entry per cycle during INIT, writeback only when READY
   always_ff @(posedge clock) begin
      if (!reset && !ready) regs[clr_cnt] <= '0;
      else if (!reset && wr_fire) regs[wr_addr] <= wr_data;
   end

   // asynchronous reads; x0 and the whole INIT phase read zero
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_READ; i++) begin
         rd_data[i*WIDTH +: WIDTH] = (!ready || rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == ZERO) ? '0 : regs[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
         if (wr_fire && rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr) rd_data[i*WIDTH +: WIDTH] = wr_data;
`endif
      end
   end

   regfile_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_READ(NUM_READ)) u_sb (
      .clock    (clock),
      .reset    (reset),
      .ready    (ready),
      .wr_fire  (wr_fire),
      .wr_addr  (wr_addr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .rd_addr  (rd_addr),
      .rd_busy  (rd_busy),
      .rsv_ok   (rsv_ok)
   );
endmodule
